// File: rtl/edge_line_setup_pkg.sv
// Shared definitions for the edge/line setup stage: raster defaults, widths,
// FSM encoding and the vertex-index table that defines the six edges.
package edge_line_setup_pkg;

    localparam int H_ACTIVE_DFLT = 640;
    localparam int V_ACTIVE_DFLT = 480;
    localparam int STEP_X_DFLT   = 700;

    localparam int EDGE_W    = 20;
    localparam int BAR_W     = 22;
    localparam int DIFF_W    = EDGE_W + 1;
    localparam int PROD_W    = 2 * DIFF_W;
    localparam int NUM_VERTS = 4;
    localparam int NUM_EDGES = 6;
    localparam int NUM_PRODS = 2 * NUM_EDGES;
    localparam int NUM_BARS  = 4;
    localparam int CNT_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_MUL,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Edge runs from vertex a to vertex b.
    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
    } edge_ends_t;

    // Entries 0..2: triangle 1 (v0,v1,v2); entries 3..5: triangle 2 (v0,v2,v3).
    localparam edge_ends_t EDGE_TABLE [NUM_EDGES] = '{
        '{a: 2'd0, b: 2'd1},
        '{a: 2'd1, b: 2'd2},
        '{a: 2'd2, b: 2'd0},
        '{a: 2'd0, b: 2'd2},
        '{a: 2'd2, b: 2'd3},
        '{a: 2'd3, b: 2'd0}
    };

    // Sign-extend a screen coordinate to the difference/operand width.
    function automatic logic signed [DIFF_W-1:0] sext_diff(input logic signed [EDGE_W-1:0] v);
        return DIFF_W'(v);
    endfunction

endpackage

// File: rtl/edge_line_setup_mul.sv
// Registered signed multiplier shared by all twelve setup products.
// Only the low EDGE_W bits leave the block: every consumer works modulo 2^EDGE_W.
module setup_mul
    import edge_line_setup_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic signed [DIFF_W-1:0] op_a,
    input  logic signed [DIFF_W-1:0] op_b,
    output logic                     out_valid,
    output logic signed [EDGE_W-1:0] prod
);

    logic                     valid_d, valid_q;
    logic signed [EDGE_W-1:0] prod_d, prod_q;

    // Full-width signed product, wrapped to the edge width.
    always_comb begin
        valid_d = in_valid;
        prod_d  = EDGE_W'(PROD_W'(op_a) * PROD_W'(op_b));
    end

    // One-cycle pipeline register for product and its valid flag.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values, whatever the statement order.
        if (reset) begin
            valid_q <= 1'b0;
            prod_q  <= '0;
        end else begin
            valid_q <= valid_d;
            prod_q  <= prod_d;
        end
    end

    assign out_valid = valid_q;
    assign prod      = prod_q;

endmodule

// File: rtl/edge_line_setup.sv
// Per-frame edge setup and per-line stepping of edge and barycentric origins
// feeding the rasterizer. Frame setup starts on (x=0, y=V_ACTIVE).
module edge_line_setup
    import edge_line_setup_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DFLT,
    parameter int V_ACTIVE = V_ACTIVE_DFLT,
    parameter int STEP_X   = STEP_X_DFLT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [9:0]               x,
    input  logic [9:0]               y,
    input  logic signed [EDGE_W-1:0] x_v0,
    input  logic signed [EDGE_W-1:0] x_v1,
    input  logic signed [EDGE_W-1:0] x_v2,
    input  logic signed [EDGE_W-1:0] x_v3,
    input  logic signed [EDGE_W-1:0] y_v0,
    input  logic signed [EDGE_W-1:0] y_v1,
    input  logic signed [EDGE_W-1:0] y_v2,
    input  logic signed [EDGE_W-1:0] y_v3,
    input  logic signed [BAR_W-1:0]  bar_iy_org,
    input  logic signed [BAR_W-1:0]  bar_iz_org,
    input  logic signed [BAR_W-1:0]  bar2_iy_org,
    input  logic signed [BAR_W-1:0]  bar2_iz_org,
    input  logic signed [BAR_W-1:0]  bar_iy_dy,
    input  logic signed [BAR_W-1:0]  bar_iz_dy,
    input  logic signed [BAR_W-1:0]  bar2_iy_dy,
    input  logic signed [BAR_W-1:0]  bar2_iz_dy,
    output logic signed [EDGE_W-1:0] e0_init_t1,
    output logic signed [EDGE_W-1:0] e1_init_t1,
    output logic signed [EDGE_W-1:0] e2_init_t1,
    output logic signed [EDGE_W-1:0] e0_init_t2,
    output logic signed [EDGE_W-1:0] e1_init_t2,
    output logic signed [EDGE_W-1:0] e2_init_t2,
    output logic signed [BAR_W-1:0]  bar_iy,
    output logic signed [BAR_W-1:0]  bar_iz,
    output logic signed [BAR_W-1:0]  bar2_iy,
    output logic signed [BAR_W-1:0]  bar2_iz,
    output logic                     busy
);

    // Stepping before the rasterizer's load column would corrupt the line being
    // drawn, so a configuration with STEP_X <= H_ACTIVE never steps.
    localparam bit STEP_AFTER_LOAD = (STEP_X > H_ACTIVE);

    state_t                   state_d, state_q;
    logic [CNT_W-1:0]         mul_cnt_d, mul_cnt_q;
    logic [CNT_W-1:0]         acc_cnt_d, acc_cnt_q;
    logic signed [EDGE_W-1:0] vx_d [NUM_VERTS], vx_q [NUM_VERTS];
    logic signed [EDGE_W-1:0] vy_d [NUM_VERTS], vy_q [NUM_VERTS];
    logic signed [DIFF_W-1:0] dx_d [NUM_EDGES], dx_q [NUM_EDGES];
    logic signed [DIFF_W-1:0] dy_d [NUM_EDGES], dy_q [NUM_EDGES];
    logic signed [EDGE_W-1:0] acc_d [NUM_EDGES], acc_q [NUM_EDGES];
    logic signed [EDGE_W-1:0] e_d [NUM_EDGES], e_q [NUM_EDGES];
    logic signed [BAR_W-1:0]  org_d [NUM_BARS], org_q [NUM_BARS];
    logic signed [BAR_W-1:0]  bdy_d [NUM_BARS], bdy_q [NUM_BARS];
    logic signed [BAR_W-1:0]  bar_d [NUM_BARS], bar_q [NUM_BARS];

    logic signed [EDGE_W-1:0] vx_in [NUM_VERTS], vy_in [NUM_VERTS];
    logic signed [BAR_W-1:0]  org_in [NUM_BARS], bdy_in [NUM_BARS];

    logic                     frame_trig, line_step;
    logic [2:0]               mul_edge, acc_edge;
    logic signed [DIFF_W-1:0] op_a, op_b;
    logic                     prod_valid;
    logic signed [EDGE_W-1:0] prod;

    assign frame_trig = (y == 10'(V_ACTIVE)) && (x == '0);
    assign line_step  = STEP_AFTER_LOAD && (state_q == ST_IDLE)
                        && (y < 10'(V_ACTIVE - 1)) && (x == 10'(STEP_X));
    assign mul_edge   = mul_cnt_q[CNT_W-1:1];
    assign acc_edge   = acc_cnt_q[CNT_W-1:1];

    // Gather the flat input ports into indexable arrays.
    always_comb begin
        vx_in  = '{x_v0, x_v1, x_v2, x_v3};
        vy_in  = '{y_v0, y_v1, y_v2, y_v3};
        org_in = '{bar_iy_org, bar_iz_org, bar2_iy_org, bar2_iz_org};
        bdy_in = '{bar_iy_dy, bar_iz_dy, bar2_iy_dy, bar2_iz_dy};
    end

    // Multiplier operand select: even product ya*dx, odd product xa*dy.
    always_comb begin
        if (!mul_cnt_q[0]) begin
            op_a = sext_diff(vy_q[EDGE_TABLE[mul_edge].a]);
            op_b = dx_q[mul_edge];
        end else begin
            op_a = sext_diff(vx_q[EDGE_TABLE[mul_edge].a]);
            op_b = dy_q[mul_edge];
        end
    end

    setup_mul u_mul (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (state_q == ST_MUL),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (prod_valid),
        .prod      (prod)
    );

    // Next-state, latch, accumulate and line-step logic.
    always_comb begin
        // NOTE: every _d starts from its held value so no path through the case can infer a latch.
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        acc_cnt_d = acc_cnt_q;
        vx_d      = vx_q;
        vy_d      = vy_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        acc_d     = acc_q;
        e_d       = e_q;
        org_d     = org_q;
        bdy_d     = bdy_q;
        bar_d     = bar_q;

        unique case (state_q)
            ST_IDLE: begin
                if (frame_trig) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                vx_d  = vx_in;
                vy_d  = vy_in;
                org_d = org_in;
                bdy_d = bdy_in;
                for (int k = 0; k < NUM_EDGES; k++) begin
                    dx_d[k]  = sext_diff(vx_in[EDGE_TABLE[k].b]) - sext_diff(vx_in[EDGE_TABLE[k].a]);
                    dy_d[k]  = sext_diff(vy_in[EDGE_TABLE[k].b]) - sext_diff(vy_in[EDGE_TABLE[k].a]);
                    acc_d[k] = '0;
                end
                mul_cnt_d = '0;
                acc_cnt_d = '0;
                state_d   = ST_MUL;
            end
            ST_MUL: begin
                if (mul_cnt_q == CNT_W'(NUM_PRODS - 1)) begin
                    mul_cnt_d = '0;
                    state_d   = ST_DRAIN;
                end else begin
                    mul_cnt_d = mul_cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                e_d     = acc_q;
                bar_d   = org_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // e(0,0) = ya*dx - xa*dy, built one product at a time.
        if (prod_valid) begin
            if (acc_cnt_q[0]) acc_d[acc_edge] = acc_q[acc_edge] - prod;
            else              acc_d[acc_edge] = acc_q[acc_edge] + prod;
            acc_cnt_d = (acc_cnt_q == CNT_W'(NUM_PRODS - 1)) ? '0 : acc_cnt_q + 1'b1;
        end

        // Advance to the next line: the edge step is xa-xb = -dx.
        if (line_step) begin
            for (int k = 0; k < NUM_EDGES; k++) e_d[k] = e_q[k] - EDGE_W'(dx_q[k]);
            for (int i = 0; i < NUM_BARS; i++)  bar_d[i] = bar_q[i] + bdy_q[i];
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mul_cnt_q <= '0;
            acc_cnt_q <= '0;
            // NOTE: these arrays are small flop banks, not RAM, so they reset like any other flop.
            vx_q      <= '{default: '0};
            vy_q      <= '{default: '0};
            dx_q      <= '{default: '0};
            dy_q      <= '{default: '0};
            acc_q     <= '{default: '0};
            e_q       <= '{default: '0};
            org_q     <= '{default: '0};
            bdy_q     <= '{default: '0};
            bar_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            acc_cnt_q <= acc_cnt_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            acc_q     <= acc_d;
            e_q       <= e_d;
            org_q     <= org_d;
            bdy_q     <= bdy_d;
            bar_q     <= bar_d;
        end
    end

    assign e0_init_t1 = e_q[0];
    assign e1_init_t1 = e_q[1];
    assign e2_init_t1 = e_q[2];
    assign e0_init_t2 = e_q[3];
    assign e1_init_t2 = e_q[4];
    assign e2_init_t2 = e_q[5];
    assign bar_iy     = bar_q[0];
    assign bar_iz     = bar_q[1];
    assign bar2_iy    = bar_q[2];
    assign bar2_iz    = bar_q[3];
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_edge_line_setup.sv
// Directed bench for edge_line_setup: reset, frame setup latency and values,
// line stepping, frame-latched inputs, dropped steps while busy, and wrap.
module tb_edge_line_setup;

    logic               clk = 1'b0;
    logic               reset;
    logic [9:0]         x, y;
    logic signed [19:0] x_v0, x_v1, x_v2, x_v3;
    logic signed [19:0] y_v0, y_v1, y_v2, y_v3;
    logic [21:0]        bar_iy_org, bar_iz_org, bar2_iy_org, bar2_iz_org;
    logic [21:0]        bar_iy_dy, bar_iz_dy, bar2_iy_dy, bar2_iz_dy;
    logic signed [19:0] e0_init_t1, e1_init_t1, e2_init_t1;
    logic signed [19:0] e0_init_t2, e1_init_t2, e2_init_t2;
    logic [21:0]        bar_iy, bar_iz, bar2_iy, bar2_iz;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int busy_cycles;
    int e_during;

    edge_line_setup dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .x_v0        (x_v0),
        .x_v1        (x_v1),
        .x_v2        (x_v2),
        .x_v3        (x_v3),
        .y_v0        (y_v0),
        .y_v1        (y_v1),
        .y_v2        (y_v2),
        .y_v3        (y_v3),
        .bar_iy_org  (bar_iy_org),
        .bar_iz_org  (bar_iz_org),
        .bar2_iy_org (bar2_iy_org),
        .bar2_iz_org (bar2_iz_org),
        .bar_iy_dy   (bar_iy_dy),
        .bar_iz_dy   (bar_iz_dy),
        .bar2_iy_dy  (bar2_iy_dy),
        .bar2_iz_dy  (bar2_iz_dy),
        .e0_init_t1  (e0_init_t1),
        .e1_init_t1  (e1_init_t1),
        .e2_init_t1  (e2_init_t1),
        .e0_init_t2  (e0_init_t2),
        .e1_init_t2  (e1_init_t2),
        .e2_init_t2  (e2_init_t2),
        .bar_iy      (bar_iy),
        .bar_iz      (bar_iz),
        .bar2_iy     (bar2_iy),
        .bar2_iz     (bar2_iz),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_verts(input int x0, input int y0, input int x1, input int y1,
                             input int x2, input int y2, input int x3, input int y3);
        x_v0 = 20'(x0); y_v0 = 20'(y0);
        x_v1 = 20'(x1); y_v1 = 20'(y1);
        x_v2 = 20'(x2); y_v2 = 20'(y2);
        x_v3 = 20'(x3); y_v3 = 20'(y3);
    endtask

    // Fire the frame trigger, then hold (hold_x, hold_y) while busy. Returns the
    // number of busy samples and e0_init_t1 as seen on the last busy sample.
    task automatic frame_setup(input int hold_x, input int hold_y,
                               output int n_busy, output int e_last);
        x = 10'd0;
        y = 10'd480;
        tick();
        x = 10'(hold_x);
        y = 10'(hold_y);
        n_busy = 0;
        e_last = 0;
        while (busy && n_busy < 40) begin
            n_busy++;
            e_last = e0_init_t1;
            tick();
        end
        x = 10'd1;
        y = 10'd481;
    endtask

    task automatic step_row(input int r);
        y = 10'(r);
        x = 10'd700;
        tick();
        x = 10'd701;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        x = 10'd0;
        y = 10'd0;
        set_verts(100, 100, 200, 100, 150, 200, 50, 200);
        bar_iy_org  = 22'h040000; bar_iy_dy  = 22'h000100;
        bar_iz_org  = 22'h3FFF00; bar_iz_dy  = 22'h000200;
        bar2_iy_org = 22'h100000; bar2_iy_dy = 22'h3FFFFF;
        bar2_iz_org = 22'h1FFFFF; bar2_iz_dy = 22'h000001;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("reset_e0_t1", e0_init_t1, 0);
        check("reset_bar_iy", bar_iy, 0);
        check("reset_busy", busy, 0);

        // Frame 1; a step condition is held through setup and must be dropped.
        frame_setup(700, 0, busy_cycles, e_during);
        check("f1_busy_cycles", busy_cycles, 15);
        check("f1_e0_t1_while_busy", e_during, 0);
        check("f1_e0_t1", e0_init_t1, 10000);
        check("f1_e1_t1", e1_init_t1, -25000);
        check("f1_e2_t1", e2_init_t1, 5000);
        check("f1_e0_t2", e0_init_t2, -5000);
        check("f1_e1_t2", e1_init_t2, -20000);
        check("f1_e2_t2", e2_init_t2, 15000);
        check("f1_bar_iy", bar_iy, 32'h040000);
        check("f1_bar_iz", bar_iz, 32'h3FFF00);
        check("f1_bar2_iy", bar2_iy, 32'h100000);
        check("f1_bar2_iz", bar2_iz, 32'h1FFFFF);

        // Mid-frame input changes must not reach this frame's outputs.
        x_v1 = 20'sd300;
        bar_iy_org = 22'h001000;
        x = 10'd640;
        y = 10'd0;
        tick();
        check("load_col_no_step", e0_init_t1, 10000);

        step_row(0);
        check("row0_e0_t1", e0_init_t1, 9900);
        check("row0_e1_t1", e1_init_t1, -24950);
        check("row0_bar_iy", bar_iy, 32'h040100);
        check("row0_bar_iz_wrap", bar_iz, 32'h000100);
        check("row0_bar2_iy", bar2_iy, 32'h0FFFFF);
        check("row0_bar2_iz_wrap", bar2_iz, 32'h200000);

        for (int r = 1; r <= 478; r++) step_row(r);
        check("row478_e0_t1", e0_init_t1, -37900);
        check("row478_e2_t2", e2_init_t2, -8950);
        check("row478_bar_iy", bar_iy, 32'h05DF00);

        step_row(479);
        check("row479_no_step", e0_init_t1, -37900);
        step_row(480);
        step_row(500);
        check("vblank_no_step", e0_init_t1, -37900);
        check("vblank_bar_iy", bar_iy, 32'h05DF00);

        // Frame 2 picks up the changed vertex and origin.
        frame_setup(700, 0, busy_cycles, e_during);
        check("f2_busy_cycles", busy_cycles, 15);
        check("f2_e0_t1", e0_init_t1, 20000);
        check("f2_e1_t1", e1_init_t1, -45000);
        check("f2_bar_iy", bar_iy, 32'h001000);

        // Reset in the middle of MUL aborts setup; nothing resumes afterwards.
        set_verts(-300000, 0, 0, 1000, 0, 0, 0, -1000);
        x = 10'd0;
        y = 10'd480;
        tick();
        x = 10'd1;
        repeat (4) tick();
        check("mid_mul_busy", busy, 1);
        reset = 1'b1;
        repeat (3) tick();
        check("abort_e0_t1", e0_init_t1, 0);
        check("abort_e2_t2", e2_init_t2, 0);
        check("abort_bar_iy", bar_iy, 0);
        check("abort_busy", busy, 0);
        reset = 1'b0;
        x = 10'd5;
        y = 10'd480;
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy) busy_cycles++;
        end
        check("no_resume_busy", busy_cycles, 0);
        check("no_resume_e0_t1", e0_init_t1, 0);

        // Wrap frame: 300000*1000 = 300000000, low 20 bits = 107264.
        frame_setup(1, 481, busy_cycles, e_during);
        check("wrap_busy_cycles", busy_cycles, 15);
        check("wrap_e0_t1", e0_init_t1, 107264);
        check("wrap_e1_t1", e1_init_t1, 0);
        check("wrap_e2_t2", e2_init_t2, 107264);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
